// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//   Waits a settle window after reset, latches the upstream panel ID, picks the
//   matching horizontal/vertical timing set and then free-runs the RGB LCD
//   raster, producing sync/DE/backlight plus a one-cycle-early pixel request.
//
// Ports:
//   clk           pixel clock
//   rst           synchronous active-high reset
//   ID_lcd[15:0]  panel ID from the ID read stage (sampled once, in LOAD)
//   lcd_hs/lcd_vs active-low horizontal / vertical sync
//   lcd_de        data enable
//   lcd_bl        backlight enable
//   data_req      pixel request, one cycle ahead of lcd_de
//   pixel_xpos/pixel_ypos  coordinates of the requested pixel
//   h_disp/v_disp active size of the selected panel
//   id_sel[15:0]  ID in use (DEF_ID when the input matched no table entry)
//   timing_valid  high while the raster is running
module lcd_timing_gen #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [15:0] DEF_ID        = 16'h4342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ID_lcd,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic        lcd_bl,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic [15:0] id_sel,
  output logic        timing_valid
);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2
  } state_t;

  typedef struct packed {
    logic [10:0] hsync;
    logic [10:0] hbp;
    logic [10:0] hdisp;
    logic [10:0] htotal;
    logic [10:0] vsync;
    logic [10:0] vbp;
    logic [10:0] vdisp;
    logic [10:0] vtotal;
  } timing_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  function automatic logic id_known(input logic [15:0] id);
    case (id)
      16'h4342, 16'h7084, 16'h7016, 16'h1018: id_known = 1'b1;
      default:                                id_known = 1'b0;
    endcase
  endfunction

  // Unknown IDs fall back to the 4342 set so a DEF_ID outside the table
  // still yields a usable raster.
  function automatic timing_t lookup(input logic [15:0] id);
    timing_t t;
    case (id)
      16'h7084: t = '{11'd128, 11'd88,  11'd800,  11'd1056, 11'd2,  11'd33, 11'd480, 11'd525};
      16'h7016: t = '{11'd20,  11'd140, 11'd1024, 11'd1344, 11'd3,  11'd20, 11'd600, 11'd635};
      16'h1018: t = '{11'd10,  11'd80,  11'd1280, 11'd1440, 11'd3,  11'd10, 11'd800, 11'd823};
      default:  t = '{11'd41,  11'd2,   11'd480,  11'd525,  11'd10, 11'd2,  11'd272, 11'd286};
    endcase
    return t;
  endfunction

  state_t      r_state, w_next;
  logic [7:0]  r_settle;
  logic [10:0] r_h_cnt, r_v_cnt;
  logic [15:0] r_id_sel;
  logic [10:0] r_h_disp, r_v_disp;
  // Pre-computed window boundaries so the RUN decodes are pure compares.
  logic [10:0] r_h_sync, r_h_req0, r_h_req1, r_h_act0, r_h_act1, r_h_last;
  logic [10:0] r_v_sync, r_v_act0, r_v_act1, r_v_last;

  logic [15:0] w_sel_id;
  timing_t     w_lut;
  logic        w_h_wrap, w_h_req, w_h_act, w_v_act;

  assign w_sel_id = id_known(ID_lcd) ? ID_lcd : DEF_ID;
  assign w_lut    = lookup(w_sel_id);

  always_ff @(posedge clk) begin
    if (rst) r_state <= SETTLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SETTLE:  if (r_settle == SETTLE_LAST) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     w_next = RUN;
      default: w_next = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
    end else if (r_state == SETTLE && r_settle != SETTLE_LAST) begin
      r_settle <= r_settle + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_sel <= '0;
      r_h_disp <= '0;
      r_v_disp <= '0;
      r_h_sync <= '0;
      r_h_req0 <= '0;
      r_h_req1 <= '0;
      r_h_act0 <= '0;
      r_h_act1 <= '0;
      r_h_last <= '0;
      r_v_sync <= '0;
      r_v_act0 <= '0;
      r_v_act1 <= '0;
      r_v_last <= '0;
    end else if (r_state == LOAD) begin
      r_id_sel <= w_sel_id;
      r_h_disp <= w_lut.hdisp;
      r_v_disp <= w_lut.vdisp;
      r_h_sync <= w_lut.hsync;
      r_h_act0 <= w_lut.hsync + w_lut.hbp;
      r_h_act1 <= w_lut.hsync + w_lut.hbp + w_lut.hdisp;
      r_h_req0 <= w_lut.hsync + w_lut.hbp - 11'd1;
      r_h_req1 <= w_lut.hsync + w_lut.hbp + w_lut.hdisp - 11'd1;
      r_h_last <= w_lut.htotal - 11'd1;
      r_v_sync <= w_lut.vsync;
      r_v_act0 <= w_lut.vsync + w_lut.vbp;
      r_v_act1 <= w_lut.vsync + w_lut.vbp + w_lut.vdisp;
      r_v_last <= w_lut.vtotal - 11'd1;
    end
  end

  assign w_h_wrap = (r_h_cnt == r_h_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_state == RUN) begin
      r_h_cnt <= w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
      if (w_h_wrap) r_v_cnt <= (r_v_cnt == r_v_last) ? 11'd0 : r_v_cnt + 11'd1;
    end
  end

  assign w_h_req = (r_h_cnt >= r_h_req0) && (r_h_cnt < r_h_req1);
  assign w_h_act = (r_h_cnt >= r_h_act0) && (r_h_cnt < r_h_act1);
  assign w_v_act = (r_v_cnt >= r_v_act0) && (r_v_cnt < r_v_act1);

  always_comb begin
    lcd_hs       = 1'b1;
    lcd_vs       = 1'b1;
    lcd_de       = 1'b0;
    lcd_bl       = 1'b0;
    data_req     = 1'b0;
    pixel_xpos   = '0;
    pixel_ypos   = '0;
    timing_valid = 1'b0;
    if (r_state == RUN) begin
      timing_valid = 1'b1;
      lcd_bl       = 1'b1;
      lcd_hs       = !(r_h_cnt < r_h_sync);
      lcd_vs       = !(r_v_cnt < r_v_sync);
      lcd_de       = w_h_act && w_v_act;
      data_req     = w_h_req && w_v_act;
      if (data_req) begin
        pixel_xpos = r_h_cnt - r_h_req0;
        pixel_ypos = r_v_cnt - r_v_act0;
      end
    end
  end

  assign h_disp = r_h_disp;
  assign v_disp = r_v_disp;
  assign id_sel = r_id_sel;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: reset values, settle latency, ID
// selection, sync/DE/request windows for 4342 and 7016, ID fallback, ID
// changes during RUN and a mid-frame reset.
module tb_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ID_lcd = 16'h4342;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, data_req, timing_valid;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic [15:0] id_sel;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  lcd_timing_gen #(.SETTLE_CYCLES(16), .DEF_ID(16'h4342)) dut (
    .clk(clk), .rst(rst), .ID_lcd(ID_lcd),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_bl(lcd_bl),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .h_disp(h_disp), .v_disp(v_disp), .id_sel(id_sel),
    .timing_valid(timing_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse reset, release it and count negedges until timing_valid; on
  // return the current sample is the first RUN cycle (h=0, v=0).
  task automatic restart(input logic [15:0] id, output int unsigned lat);
    ID_lcd = id;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (timing_valid) break;
    end
  endtask

  initial begin
    int unsigned lat;
    int unsigned hs_lo, vs_lo, de_n, req_n;
    int unsigned h, v;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hs", lcd_hs, 1);
    check("rst_vs", lcd_vs, 1);
    check("rst_de", lcd_de, 0);
    check("rst_bl", lcd_bl, 0);
    check("rst_req", data_req, 0);
    check("rst_tv", timing_valid, 0);
    check("rst_id", id_sel, 0);
    check("rst_hdisp", h_disp, 0);

    // 4342: latency, table values, 14 lines of raster, then reset at (300,100)
    restart(16'h4342, lat);
    check("lat_4342", lat, 17);
    check("hdisp_4342", h_disp, 480);
    check("vdisp_4342", v_disp, 272);
    check("id_4342", id_sel, 16'h4342);
    check("bl_run", lcd_bl, 1);
    hs_lo = 0; vs_lo = 0; de_n = 0; req_n = 0;
    for (int unsigned i = 0; i < 14 * 525; i++) begin
      h = i % 525; v = i / 525;
      hs_lo += (lcd_hs == 1'b0) ? 1 : 0;
      vs_lo += (lcd_vs == 1'b0) ? 1 : 0;
      de_n  += lcd_de ? 1 : 0;
      req_n += data_req ? 1 : 0;
      if (v == 12) begin
        if (h == 41)  check("l12_req_h41", data_req, 0);
        if (h == 42) begin
          check("l12_req_h42", data_req, 1);
          check("l12_x_h42", pixel_xpos, 0);
          check("l12_y_h42", pixel_ypos, 0);
          check("l12_de_h42", lcd_de, 0);
        end
        if (h == 43)  check("l12_de_h43", lcd_de, 1);
        if (h == 521) begin
          check("l12_req_h521", data_req, 1);
          check("l12_x_h521", pixel_xpos, 479);
        end
        if (h == 522) begin
          check("l12_req_h522", data_req, 0);
          check("l12_x_h522", pixel_xpos, 0);
          check("l12_de_h522", lcd_de, 1);
        end
        if (h == 523) check("l12_de_h523", lcd_de, 0);
      end
      if (v == 11 && h == 100) check("l11_de", lcd_de, 0);
      if (v == 13 && h == 42)  check("l13_y", pixel_ypos, 1);
      @(negedge clk);
    end
    check("hs_low_cnt", hs_lo, 14 * 41);
    check("vs_low_cnt", vs_lo, 5250);
    check("de_cnt_14l", de_n, 960);
    check("req_cnt_14l", req_n, 960);

    // Advance to h=300, v=100 and pulse reset there
    for (int unsigned i = 14 * 525; i < 100 * 525 + 300; i++) @(negedge clk);
    check("mid_req", data_req, 1);
    check("mid_x", pixel_xpos, 258);
    check("mid_y", pixel_ypos, 88);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_de", lcd_de, 0);
    check("mrst_hs", lcd_hs, 1);
    check("mrst_vs", lcd_vs, 1);
    check("mrst_bl", lcd_bl, 0);
    check("mrst_tv", timing_valid, 0);
    rst = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (timing_valid) break;
    end
    check("mrst_lat", lat, 17);
    check("mrst_vs0", lcd_vs, 0);
    repeat (40) @(negedge clk);
    check("mrst_hs_h40", lcd_hs, 0);
    @(negedge clk);
    check("mrst_hs_h41", lcd_hs, 1);
    @(negedge clk);
    check("mrst_req_v0", data_req, 0);

    // Unknown ID falls back; ID changes during RUN are ignored
    restart(16'h1234, lat);
    check("lat_1234", lat, 17);
    check("id_fallback", id_sel, 16'h4342);
    check("hdisp_fallback", h_disp, 480);
    ID_lcd = 16'h7084;
    hs_lo = 0;
    for (int unsigned i = 0; i < 525; i++) begin
      hs_lo += (lcd_hs == 1'b0) ? 1 : 0;
      @(negedge clk);
    end
    check("hs_after_idchg", hs_lo, 41);
    check("id_after_idchg", id_sel, 16'h4342);
    check("hdisp_after_idchg", h_disp, 480);
    check("vdisp_after_idchg", v_disp, 272);

    // 7016: line length and first active line
    restart(16'h7016, lat);
    check("id_7016", id_sel, 16'h7016);
    check("hdisp_7016", h_disp, 1024);
    check("vdisp_7016", v_disp, 600);
    hs_lo = 0; de_n = 0;
    for (int unsigned i = 0; i < 24 * 1344; i++) begin
      h = i % 1344; v = i / 1344;
      if (v == 0) hs_lo += (lcd_hs == 1'b0) ? 1 : 0;
      de_n += lcd_de ? 1 : 0;
      if (v == 1 && h == 0)    check("7016_hs_wrap", lcd_hs, 0);
      if (v == 0 && h == 1343) check("7016_hs_end", lcd_hs, 1);
      if (v == 23 && h == 159) check("7016_req", data_req, 1);
      if (v == 23 && h == 160) check("7016_de", lcd_de, 1);
      @(negedge clk);
    end
    check("7016_hs_low", hs_lo, 20);
    check("7016_de_cnt", de_n, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
